// File: rtl/alu_pkg.sv
// Shared types for the EX-stage execute unit.
//   alu_op_e  : base RV32I ALU encodings (op[3:0] when op[4]=0)
//   md_op_e   : M-extension encodings    (op[2:0] when op[4]=1)
//   state_e   : execute-unit FSM states
//   md_sign_t : operand signedness of an M op, returned by md_signs()
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_e;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   typedef struct packed {
      logic a_signed;
      logic b_signed;
   } md_sign_t;

   // The low product half is sign-agnostic, so mul is treated as signed x signed.
   function automatic md_sign_t md_signs(input md_op_e o);
      md_sign_t s;
      case (o)
         MD_MUL, MD_MULH, MD_DIV, MD_REM: s = '{a_signed: 1'b1, b_signed: 1'b1};
         MD_MULHSU:                       s = '{a_signed: 1'b1, b_signed: 1'b0};
         default:                         s = '{a_signed: 1'b0, b_signed: 1'b0};
      endcase
      return s;
   endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide datapath, one bit per cycle on operand magnitudes.
//   clk, rst_n         : clock, async active-low reset
//   flush              : abandon the current iteration
//   start              : load a/b and begin (one-cycle pulse)
//   is_div             : 1 = restoring divide, 0 = shift-add multiply
//   a_signed, b_signed : take the magnitude of a/b before iterating
//   a, b               : operands, sampled only on start
//   done               : high during the final iteration cycle
//   hi, lo             : state after the current step; at done they hold
//                        product[2X-1:X]/product[X-1:0] or remainder/quotient
module alu_md_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            start,
   input  logic            is_div,
   input  logic            a_signed,
   input  logic            b_signed,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CNT_W = $clog2(XLEN);

   logic [XLEN:0]   acc_q, acc_nxt;   // partial product high half / partial remainder
   logic [XLEN-1:0] lo_q, lo_nxt;     // multiplier being consumed / quotient being built
   logic [XLEN-1:0] opnd_q;           // multiplicand or divisor magnitude
   logic            is_div_q;
   logic            running_q;
   logic [CNT_W-1:0] cnt_q;

   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   sum, shifted;
   logic [XLEN+1:0] trial;

   assign mag_a = (a_signed && a[XLEN-1]) ? -a : a;
   assign mag_b = (b_signed && b[XLEN-1]) ? -b : b;

   // NOTE: every signal written here gets a value before any branch, otherwise a latch is inferred.
   always_comb begin
      sum     = acc_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
      shifted = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
      trial   = {1'b0, shifted} - {2'b00, opnd_q};
      acc_nxt = acc_q;
      lo_nxt  = lo_q;
      if (is_div_q) begin
         // Restoring step: keep the subtraction only if it did not borrow.
         if (!trial[XLEN+1]) begin
            acc_nxt = trial[XLEN:0];
            lo_nxt  = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            acc_nxt = shifted;
            lo_nxt  = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         {acc_nxt, lo_nxt} = {sum, lo_q} >> 1;
      end
   end

   assign done = running_q && (cnt_q == CNT_W'(XLEN - 1));
   assign hi   = acc_nxt[XLEN-1:0];
   assign lo   = lo_nxt;

   // NOTE: state is assigned with <= so every register samples pre-edge values.
   // NOTE: the datapath registers are reset too; they are few and this keeps
   // post-reset behaviour fully deterministic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         lo_q      <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         running_q <= 1'b0;
         cnt_q     <= '0;
      end else if (flush) begin
         running_q <= 1'b0;
         cnt_q     <= '0;
      end else if (start) begin
         acc_q     <= '0;
         lo_q      <= is_div ? mag_a : mag_b;
         opnd_q    <= is_div ? mag_b : mag_a;
         is_div_q  <= is_div;
         running_q <= 1'b1;
         cnt_q     <= '0;
      end else if (running_q) begin
         acc_q <= acc_nxt;
         lo_q  <= lo_nxt;
         cnt_q <= cnt_q + 1'b1;
         if (done) running_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq_md.sv
// Registered EX-stage execute unit: RV32I base ALU ops plus the M extension.
//   clk, rst_n          : clock, async active-low reset
//   flush               : drop any in-flight op, back to IDLE
//   in_valid / in_ready : operand handshake; in_ready only in IDLE
//   op                  : op[4]=0 base op op[3:0]; op[4]=1 M op op[2:0]
//   a, b                : operands (rs1, rs2/imm)
//   out_valid/out_ready : result handshake; result held until taken
//   result              : registered result
//   busy                : unit not in IDLE
module alu_seq_md
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int SHAMT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   state_e   state_q;
   md_op_e   md_op_q;
   logic     neg_q;            // magnitude result must be negated at the end

   md_op_e   md_op;
   md_sign_t signs;
   logic     accept, div_by_zero, div_ovf, special, start, neg_in;
   logic [SHAMT_W-1:0] shamt;
   logic [XLEN-1:0]    base_res, special_res, fix_res;
   logic               iter_done;
   logic [XLEN-1:0]    iter_hi, iter_lo;
   logic [2*XLEN-1:0]  prod, prod_s;

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign accept   = in_valid && in_ready && !flush;

   assign shamt = b[SHAMT_W-1:0];
   assign md_op = md_op_e'(op[2:0]);
   assign signs = md_signs(md_op);

   always_comb begin
      base_res = '0;
      case (alu_op_e'(op[3:0]))
         ALU_ADD:  base_res = a + b;
         ALU_SUB:  base_res = a - b;
         ALU_SLL:  base_res = a << shamt;
         ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
         ALU_XOR:  base_res = a ^ b;
         ALU_SRL:  base_res = a >> shamt;
         ALU_SRA:  base_res = $unsigned($signed(a) >>> shamt);
         ALU_OR:   base_res = a | b;
         ALU_AND:  base_res = a & b;
         default:  base_res = '0;
      endcase
   end

   // Divide special cases finish in one cycle without touching the iterator.
   // op[1] separates rem/remu from div/divu, op[0] marks the unsigned forms.
   assign div_by_zero = op[2] && (b == '0);
   assign div_ovf     = op[2] && !op[0] && (a == MIN_INT) && (b == '1);
   assign special     = div_by_zero || div_ovf;
   assign special_res = div_by_zero ? (op[1] ? a : '1)
                                    : (op[1] ? '0 : MIN_INT);
   assign start       = accept && op[4] && !special;

   // Remainder takes the dividend's sign; product and quotient the xor of both.
   assign neg_in = (op[2] && op[1])
                 ? (signs.a_signed && a[XLEN-1])
                 : ((signs.a_signed && a[XLEN-1]) ^ (signs.b_signed && b[XLEN-1]));

   alu_md_iter #(.XLEN(XLEN)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .start    (start),
      .is_div   (op[2]),
      .a_signed (signs.a_signed),
      .b_signed (signs.b_signed),
      .a        (a),
      .b        (b),
      .done     (iter_done),
      .hi       (iter_hi),
      .lo       (iter_lo)
   );

   assign prod   = {iter_hi, iter_lo};
   assign prod_s = neg_q ? -prod : prod;

   always_comb begin
      fix_res = '0;
      case (md_op_q)
         MD_MUL:                       fix_res = prod_s[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              fix_res = neg_q ? -iter_lo : iter_lo;
         MD_REM, MD_REMU:              fix_res = neg_q ? -iter_hi : iter_hi;
         default:                      fix_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         md_op_q   <= MD_MUL;
         neg_q     <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
      end else if (flush) begin
         state_q   <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  md_op_q <= md_op;
                  neg_q   <= neg_in;
                  if (!op[4]) begin
                     result    <= base_res;
                     out_valid <= 1'b1;
                     state_q   <= DONE;
                  end else if (special) begin
                     result    <= special_res;
                     out_valid <= 1'b1;
                     state_q   <= DONE;
                  end else begin
                     state_q <= op[2] ? DIV : MUL;
                  end
               end
            end
            MUL, DIV: begin
               if (iter_done) begin
                  result    <= fix_res;
                  out_valid <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_md.sv
// Self-checking bench for alu_seq_md (XLEN=32): directed vector table with
// latency checks, DONE hold, flush, async reset mid-op, and random ops with
// output backpressure against a behavioural reference model.
module tb_alu_seq_md;
   import alu_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op;
   logic [XLEN-1:0] a, b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   int n_checks = 0;
   int n_fail   = 0;
   logic [XLEN-1:0] sb_q[$];

   alu_seq_md #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic [4:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] exp;
      int              lat;
   } vec_t;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [4:0] bop(input alu_op_e o);
      return {1'b0, o};
   endfunction

   function automatic logic [4:0] mop(input md_op_e o);
      return {2'b10, o};
   endfunction

   // Behavioural reference using wide native arithmetic.
   function automatic logic [31:0] ref_model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy, sp;
      logic [63:0] ux, uy, up;
      int si, sj;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      ux = {32'b0, x};
      uy = {32'b0, y};
      si = x;
      sj = y;
      if (!o[4]) begin
         case (o[3:0])
            4'b0000: return x + y;
            4'b1000: return x - y;
            4'b0001: return x << y[4:0];
            4'b0010: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0011: return (x < y) ? 32'd1 : 32'd0;
            4'b0100: return x ^ y;
            4'b0101: return x >> y[4:0];
            4'b1101: return $unsigned($signed(x) >>> y[4:0]);
            4'b0110: return x | y;
            4'b0111: return x & y;
            default: return 32'd0;
         endcase
      end
      case (o[2:0])
         3'b000: begin up = ux * uy; return up[31:0]; end
         3'b001: begin sp = sx * sy; return sp[63:32]; end
         3'b010: begin sp = sx * $signed(uy); return sp[63:32]; end
         3'b011: begin up = ux * uy; return up[63:32]; end
         3'b100: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
            return si / sj;
         end
         3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'b110: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
            return si % sj;
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   task automatic wait_idle();
      int c = 0;
      while (!in_ready && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      if (!in_ready) check("idle_timeout", {63'b0, in_ready}, 64'd1);
   endtask

   // Issue one op with out_ready=1, check result and accept-to-valid latency.
   task automatic run_vec(input string nm, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] e, input int lat);
      int cyc;
      logic [31:0] exp_v;
      wait_idle();
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
      sb_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = ~o; a = $urandom; b = $urandom;   // must not disturb the accepted op
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      exp_v = sb_q.pop_front();
      if (!out_valid) begin
         check({nm, "_timeout"}, {63'b0, out_valid}, 64'd1);
      end else begin
         check(nm, {32'b0, result}, {32'b0, exp_v});
         check({nm, "_lat"}, 64'(cyc), 64'(lat));
      end
      @(posedge clk); #1;
   endtask

   vec_t vecs[$];

   initial begin
      logic seen, fin, ever_valid;
      logic [31:0] exp_r;
      logic [4:0] ro;
      logic [31:0] ra, rb;

      vecs = '{
         '{"add_ovf",    bop(ALU_ADD),  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1},
         '{"sub_wrap",   bop(ALU_SUB),  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1},
         '{"sll_31",     bop(ALU_SLL),  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1},
         '{"sll_shamt",  bop(ALU_SLL),  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1},
         '{"slt",        bop(ALU_SLT),  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1},
         '{"sltu",       bop(ALU_SLTU), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1},
         '{"xor",        bop(ALU_XOR),  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1},
         '{"srl",        bop(ALU_SRL),  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1},
         '{"sra",        bop(ALU_SRA),  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1},
         '{"or",         bop(ALU_OR),   32'hA000_0005, 32'h0500_0050, 32'hA500_0055, 1},
         '{"and",        bop(ALU_AND),  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1},
         '{"base_undef", 5'b01111,      32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1},
         '{"mulh_m1",    mop(MD_MULH),  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33},
         '{"mulhu_max",  mop(MD_MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
         '{"mul_m1",     mop(MD_MUL),   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33},
         '{"mulhsu_m1",  mop(MD_MULHSU),32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33},
         '{"mul_neg",    mop(MD_MUL),   32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 33},
         '{"mulh_neg",   mop(MD_MULH),  32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33},
         '{"mulh_min",   mop(MD_MULH),  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33},
         '{"div_neg",    mop(MD_DIV),   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33},
         '{"rem_neg",    mop(MD_REM),   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33},
         '{"div_negb",   mop(MD_DIV),   32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33},
         '{"rem_negb",   mop(MD_REM),   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33},
         '{"divu",       mop(MD_DIVU),  32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33},
         '{"remu",       mop(MD_REMU),  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33},
         '{"divu_z",     mop(MD_DIVU),  32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 1},
         '{"remu_z",     mop(MD_REMU),  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 1},
         '{"div_z",      mop(MD_DIV),   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1},
         '{"rem_z",      mop(MD_REM),   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1},
         '{"div_ovf",    mop(MD_DIV),   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
         '{"rem_ovf",    mop(MD_REM),   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1},
         '{"divu_big",   mop(MD_DIVU),  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33},
         '{"remu_big",   mop(MD_REMU),  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33},
         '{"div_op3",    5'b11100,      32'h0000_0014, 32'h0000_0003, 32'h0000_0006, 33}
      };

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; a = '0; b = '0;

      // Reset state, both during and just after reset.
      #12;
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_result",    {32'b0, result},    64'd0);
      check("rst_busy",      {63'b0, busy},      64'd0);
      check("rst_in_ready",  {63'b0, in_ready},  64'd1);
      #11 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_busy", {63'b0, busy}, 64'd0);

      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

      // Hold DONE with out_ready low; new in_valid must be ignored.
      wait_idle();
      op = bop(ALU_ADD); a = 32'd5; b = 32'd6; in_valid = 1'b1; out_ready = 1'b0;
      sb_q.push_back(32'd11);
      @(posedge clk); #1;
      op = bop(ALU_SUB); a = 32'd100; b = 32'd1;   // in_valid kept high
      for (int i = 0; i < 5; i++) begin
         check("hold_valid",    {63'b0, out_valid}, 64'd1);
         check("hold_in_ready", {63'b0, in_ready},  64'd0);
         check("hold_result",   {32'b0, result},    64'd11);
         @(posedge clk); #1;
      end
      check("hold_final", {32'b0, result}, {32'b0, sb_q.pop_front()});
      out_ready = 1'b1;
      @(posedge clk); #1;                            // handoff
      check("b2b_idle",      {63'b0, in_ready},  64'd1);
      check("b2b_no_valid",  {63'b0, out_valid}, 64'd0);
      sb_q.push_back(32'd99);
      @(posedge clk); #1;                            // back-to-back accept of sub
      in_valid = 1'b0;
      check("b2b_valid",  {63'b0, out_valid}, 64'd1);
      check("b2b_result", {32'b0, result},    {32'b0, sb_q.pop_front()});
      @(posedge clk); #1;

      // Flush at cycle 10 of a divide.
      wait_idle();
      op = mop(MD_DIV); a = 32'd1000; b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy",     {63'b0, busy},      64'd0);
      check("flush_valid",    {63'b0, out_valid}, 64'd0);
      check("flush_in_ready", {63'b0, in_ready},  64'd1);
      ever_valid = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) ever_valid = 1'b1;
      end
      check("flush_no_result", {63'b0, ever_valid}, 64'd0);

      // Flush beats a simultaneous accept.
      op = bop(ALU_ADD); a = 32'd1; b = 32'd2; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_prio_busy", {63'b0, busy}, 64'd0);
      @(posedge clk); #1;
      check("flush_prio_valid", {63'b0, out_valid}, 64'd0);

      run_vec("post_flush_div", mop(MD_DIV), 32'd1000, 32'd7, 32'd142, 33);

      // Async reset in the middle of a multiply.
      wait_idle();
      op = mop(MD_MUL); a = 32'd3; b = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      check("amid_rst_valid",    {63'b0, out_valid}, 64'd0);
      check("amid_rst_result",   {32'b0, result},    64'd0);
      check("amid_rst_busy",     {63'b0, busy},      64'd0);
      check("amid_rst_in_ready", {63'b0, in_ready},  64'd1);
      #3 rst_n = 1'b1;
      ever_valid = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) ever_valid = 1'b1;
      end
      check("amid_rst_lost", {63'b0, ever_valid}, 64'd0);
      run_vec("post_rst_mul", mop(MD_MUL), 32'd7, 32'd6, 32'd42, 33);

      // Random ops with random out_ready backpressure.
      for (int n = 0; n < 300; n++) begin
         ro = 5'($urandom_range(0, 31));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 15))
            0, 1: rb = 32'd0;
            2:    begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3:    rb = 32'($urandom_range(0, 15));
            default: ;
         endcase
         wait_idle();
         op = ro; a = ra; b = rb; in_valid = 1'b1; out_ready = 1'b0;
         sb_q.push_back(ref_model(ro, ra, rb));
         @(posedge clk); #1;
         in_valid = 1'b0; op = $urandom; a = $urandom; b = $urandom;
         seen = 1'b0; fin = 1'b0; exp_r = '0;
         for (int c = 0; c < 120 && !fin; c++) begin
            if (out_valid) begin
               if (!seen) begin
                  exp_r = sb_q.pop_front();
                  check("rnd_result", {32'b0, result}, {32'b0, exp_r});
                  seen = 1'b1;
               end else begin
                  check("rnd_hold", {32'b0, result}, {32'b0, exp_r});
               end
               out_ready = 1'($urandom_range(0, 1));
               if (out_ready) fin = 1'b1;
            end
            @(posedge clk); #1;
         end
         out_ready = 1'b0;
         if (!seen) begin
            check("rnd_timeout", {63'b0, seen}, 64'd1);
            void'(sb_q.pop_front());
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
